rps_round_judge: RTL and testbench
==================================

Name: rps_round_judge

Overview:
- Consumer end of the computer-move interface in the rock-paper-scissors slave.
- Drives the 2-bit game `state` bus that the random-move generator watches (01 = COUNTDOWN).
- Samples the generator's `com_move` at the end of the countdown and judges it against the latched player move.
- Keeps per-match scores and flags the end of the match when either side reaches WIN_TARGET round wins.

Parameters:
- CNT_CYCLES, 8, number of clk cycles spent in COUNTDOWN (≥2).
- RESULT_CYCLES, 4, number of clk cycles spent in RESULT before returning to IDLE (≥1).
- WIN_TARGET, 3, round wins needed to take the match (1..2^SCORE_W-1).
- SCORE_W, 3, width of each score counter.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to begin a round; ignored outside IDLE.
- player_valid  input  1  qualifies player_move.
- player_move  input  2  00 rock, 01 paper, 10 scissors, 11 invalid.
- com_move  input  2  computer move from the generator, same encoding.
- state  output  2  00 IDLE, 01 COUNTDOWN, 10 REVEAL, 11 RESULT.
- round_result  output  2  00 none, 01 player wins, 10 computer wins, 11 tie.
- player_mv_q  output  2  latched player move for the current round.
- com_mv_q  output  2  latched computer move for the current round.
- player_score  output  SCORE_W  player round wins in the current match.
- com_score  output  SCORE_W  computer round wins in the current match.
- match_over  output  1  high once either score reaches WIN_TARGET.
- match_winner  output  1  0 = player, 1 = computer; valid only while match_over=1.

Behaviour:

Reset (synchronous, rst=1):
- state=IDLE, round_result=00.
- player_mv_q=11, com_mv_q=11.
- Both scores 0, match_over=0, match_winner=0.
- Internal countdown counter=0, have_move flag=0.
- Reset overrides every other input in any state, including mid-COUNTDOWN or mid-RESULT.

IDLE:
- On start=1, go to COUNTDOWN next cycle and load counter=CNT_CYCLES-1.
- At the same transition: clear round_result to 00, have_move=0, player_mv_q=11.
- If match_over=1 when start arrives, also clear both scores and match_over, so a new match begins.

COUNTDOWN (state=01):
- Every cycle with player_valid=1 and player_move≠11, latch player_mv_q and set have_move=1. The last valid move before exit wins.
- player_move=11 is ignored even when player_valid=1.
- The counter decrements each cycle. In the cycle it reads 0, go to REVEAL and latch com_mv_q=com_move in the same edge.
- A player move presented in that last cycle is still accepted.
- Total COUNTDOWN duration is exactly CNT_CYCLES cycles.
- start is ignored.

REVEAL (state=10, exactly 1 cycle):
- Computer move: if com_mv_q=11, treat it as rock (00).
- Forfeit: if have_move=0, result is computer wins.
- Otherwise let d=(player − com) mod 3:
  - d=0: tie (11).
  - d=1: player wins (01).
  - d=2: computer wins (10).
- On the REVEAL→RESULT edge, register round_result and increment the winner's score (a tie changes neither score).
- In the same edge, set match_over=1 and match_winner if the new score equals WIN_TARGET.
- Scores never exceed WIN_TARGET.

RESULT (state=11):
- Hold all outputs for RESULT_CYCLES cycles, then go to IDLE.
- round_result, both scores and the latched moves remain stable through IDLE until the next start.
- start is ignored during RESULT.

Latency:
- start to state=01: 1 cycle.
- Entry to COUNTDOWN to state=10: CNT_CYCLES cycles.
- REVEAL to valid round_result/scores: 1 cycle (visible in the first RESULT cycle).

Test Plan:
- rst held 2 cycles, then released → state=00, scores 0/0, round_result=00, player_mv_q=com_mv_q=11, match_over=0.
- start; player_move=01 (paper) valid in cycle 3 of countdown; com_move=00 → state=01 for 8 cycles, 10 for 1 cycle, then 11 with round_result=01, player_score=1; IDLE after 4 RESULT cycles.
- Player presents 00 then 10 during countdown, com=10 → player_mv_q=10, round_result=11, scores unchanged.
- No player_valid during countdown, com=01 → round_result=10, com_score increments. Separately, com_move=11 with player=01 → com treated as rock, round_result=01.
- Three computer wins → com_score=3, match_over=1, match_winner=1. Next start clears scores to 0/0 and match_over to 0, and enters COUNTDOWN.
- rst asserted mid-COUNTDOWN (counter=4) → next cycle state=00 with all reset values. Separately, start pulsed during COUNTDOWN or RESULT → no effect on timing or state.

Source files
------------

// File: rtl/rps_round_judge.sv
// Round judge for the rock-paper-scissors slave: drives the game state bus,
// latches player/computer moves, scores each round and tracks the match.
module rps_round_judge #(
    parameter int CNT_CYCLES    = 8,
    parameter int RESULT_CYCLES = 4,
    parameter int WIN_TARGET    = 3,
    parameter int SCORE_W       = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               player_valid,
    input  logic [1:0]         player_move,
    input  logic [1:0]         com_move,
    output logic [1:0]         state,
    output logic [1:0]         round_result,
    output logic [1:0]         player_mv_q,
    output logic [1:0]         com_mv_q,
    output logic [SCORE_W-1:0] player_score,
    output logic [SCORE_W-1:0] com_score,
    output logic               match_over,
    output logic               match_winner
);
    typedef enum logic [1:0] {S_IDLE = 2'b00, S_CD = 2'b01, S_REV = 2'b10, S_RES = 2'b11} state_t;

    localparam int CMAX = (CNT_CYCLES > RESULT_CYCLES) ? CNT_CYCLES : RESULT_CYCLES;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam logic [SCORE_W-1:0] WT = SCORE_W'(WIN_TARGET);

    state_t             r_state, w_next;
    logic [CW-1:0]      r_cnt;
    logic               r_have;
    logic [1:0]         r_pmv, r_cmv, r_result;
    logic [SCORE_W-1:0] r_pscore, r_cscore;
    logic               r_over, r_winner;
    logic               w_go, w_cd_last, w_res_last;
    logic [1:0]         w_cmv, w_res;
    logic [2:0]         w_sum, w_d;
    logic [SCORE_W-1:0] w_pnext, w_cnext;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (start) w_next = S_CD;
            S_CD:   if (r_cnt == '0) w_next = S_REV;
            S_REV:  w_next = S_RES;
            S_RES:  if (r_cnt == '0) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        state      = r_state;
        w_go       = (r_state == S_IDLE) && start;
        w_cd_last  = (r_state == S_CD) && (r_cnt == '0);
        w_res_last = (r_state == S_RES) && (r_cnt == '0);
    end

    // An invalid computer move counts as rock; no player move forfeits the round.
    always_comb begin
        w_cmv = (r_cmv == 2'b11) ? 2'b00 : r_cmv;
        w_sum = {1'b0, r_pmv} + 3'd3 - {1'b0, w_cmv};
        w_d   = (w_sum >= 3'd3) ? w_sum - 3'd3 : w_sum;
        if (!r_have)         w_res = 2'b10;
        else if (w_d == 3'd0) w_res = 2'b11;
        else if (w_d == 3'd1) w_res = 2'b01;
        else                  w_res = 2'b10;
        w_pnext = r_pscore + 1'b1;
        w_cnext = r_cscore + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_have   <= 1'b0;
            r_pmv    <= 2'b11;
            r_cmv    <= 2'b11;
            r_result <= 2'b00;
            r_pscore <= '0;
            r_cscore <= '0;
            r_over   <= 1'b0;
            r_winner <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_go) begin
                    r_cnt    <= CW'(CNT_CYCLES - 1);
                    r_result <= 2'b00;
                    r_have   <= 1'b0;
                    r_pmv    <= 2'b11;
                    if (r_over) begin
                        r_pscore <= '0;
                        r_cscore <= '0;
                        r_over   <= 1'b0;
                        r_winner <= 1'b0;
                    end
                end
                S_CD: begin
                    if (player_valid && player_move != 2'b11) begin
                        r_pmv  <= player_move;
                        r_have <= 1'b1;
                    end
                    if (w_cd_last) r_cmv <= com_move;
                    else           r_cnt <= r_cnt - 1'b1;
                end
                S_REV: begin
                    r_result <= w_res;
                    r_cnt    <= CW'(RESULT_CYCLES - 1);
                    if (w_res == 2'b01 && r_pscore != WT) begin
                        r_pscore <= w_pnext;
                        if (w_pnext == WT) begin
                            r_over   <= 1'b1;
                            r_winner <= 1'b0;
                        end
                    end else if (w_res == 2'b10 && r_cscore != WT) begin
                        r_cscore <= w_cnext;
                        if (w_cnext == WT) begin
                            r_over   <= 1'b1;
                            r_winner <= 1'b1;
                        end
                    end
                end
                S_RES: if (!w_res_last) r_cnt <= r_cnt - 1'b1;
                default: ;
            endcase
        end
    end

    assign round_result = r_result;
    assign player_mv_q  = r_pmv;
    assign com_mv_q     = r_cmv;
    assign player_score = r_pscore;
    assign com_score    = r_cscore;
    assign match_over   = r_over;
    assign match_winner = r_winner;
endmodule

// File: tb/tb_rps_round_judge.sv
// Directed bench for rps_round_judge: round timing, judging, scoring, match end.
module tb_rps_round_judge;
    logic       clk = 1'b0;
    logic       rst, start, player_valid;
    logic [1:0] player_move, com_move;
    logic [1:0] state, round_result, player_mv_q, com_mv_q;
    logic [2:0] player_score, com_score;
    logic       match_over, match_winner;
    int n_cmp = 0, n_bad = 0;

    rps_round_judge #(.CNT_CYCLES(8), .RESULT_CYCLES(4), .WIN_TARGET(3), .SCORE_W(3)) dut (
        .clk(clk), .rst(rst), .start(start), .player_valid(player_valid),
        .player_move(player_move), .com_move(com_move), .state(state),
        .round_result(round_result), .player_mv_q(player_mv_q), .com_mv_q(com_mv_q),
        .player_score(player_score), .com_score(com_score),
        .match_over(match_over), .match_winner(match_winner));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a round, present up to two player moves at countdown cycles c1/c2,
    // and stop in the first RESULT cycle. com_move differs from cm except in
    // the final countdown cycle, so an early sample would be caught.
    task automatic play(input int c1, input logic [1:0] m1, input int c2,
                        input logic [1:0] m2, input logic [1:0] cm, input bit junk);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            chk($sformatf("cd_state_%0d", k), state, 1);
            player_valid = (k == c1) || (k == c2);
            player_move  = (k == c2) ? m2 : ((k == c1) ? m1 : 2'b00);
            com_move     = (k == 8) ? cm : cm + 2'd1;
            start        = junk && (k == 4);
            tick();
        end
        player_valid = 1'b0;
        start = 1'b0;
        chk("reveal_state", state, 2);
        tick();
        chk("result_state", state, 3);
    endtask

    task automatic fin(input bit junk);
        for (int k = 1; k <= 3; k++) begin
            start = junk && (k == 2);
            tick();
            chk($sformatf("res_hold_%0d", k), state, 3);
        end
        start = 1'b0;
        tick();
        chk("back_idle", state, 0);
    endtask

    task automatic chk_round(input string tag, input int res, input int ps, input int cs,
                             input int pm, input int cmv);
        chk({tag, "_res"}, round_result, res);
        chk({tag, "_ps"}, player_score, ps);
        chk({tag, "_cs"}, com_score, cs);
        chk({tag, "_pmv"}, player_mv_q, pm);
        chk({tag, "_cmv"}, com_mv_q, cmv);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; player_valid = 1'b0; player_move = 2'b00; com_move = 2'b00;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_state", state, 0);
        chk_round("rst", 0, 0, 0, 3, 3);
        chk("rst_over", match_over, 0);

        // paper vs rock: player wins
        play(3, 2'b01, 0, 2'b00, 2'b00, 1'b0);
        chk_round("r1", 1, 1, 0, 1, 0);
        fin(1'b0);
        chk("r1_idle_hold", round_result, 1);

        // rock then scissors; last move wins; scissors vs scissors ties
        play(2, 2'b00, 6, 2'b10, 2'b10, 1'b0);
        chk_round("r2", 3, 1, 0, 2, 2);
        fin(1'b0);

        // only an invalid move presented: forfeit to computer
        play(4, 2'b11, 0, 2'b00, 2'b01, 1'b0);
        chk_round("r3", 2, 1, 1, 3, 1);
        fin(1'b0);

        // invalid computer move treated as rock; move in last countdown cycle
        play(8, 2'b01, 0, 2'b00, 2'b11, 1'b0);
        chk_round("r4", 1, 2, 1, 1, 3);
        fin(1'b0);

        // rock vs paper twice: computer takes the match
        play(1, 2'b00, 0, 2'b00, 2'b01, 1'b0);
        chk_round("r5", 2, 2, 2, 0, 1);
        chk("r5_over", match_over, 0);
        fin(1'b0);
        play(1, 2'b00, 0, 2'b00, 2'b01, 1'b0);
        chk_round("r6", 2, 2, 3, 0, 1);
        chk("r6_over", match_over, 1);
        chk("r6_winner", match_winner, 1);
        fin(1'b0);
        chk("r6_idle_cs", com_score, 3);

        // new match; stray start pulses in countdown and result
        play(5, 2'b10, 0, 2'b00, 2'b01, 1'b1);
        chk_round("r7", 1, 1, 0, 2, 1);
        chk("r7_over", match_over, 0);
        fin(1'b1);

        // reset while the countdown counter reads 4
        start = 1'b1; tick(); start = 1'b0;
        player_valid = 1'b1; player_move = 2'b01;
        tick(); tick();
        player_valid = 1'b0;
        tick();
        chk("pre_rst_state", state, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_state", state, 0);
        chk_round("mid_rst", 0, 0, 0, 3, 3);
        chk("mid_rst_over", match_over, 0);
        tick();
        chk("mid_rst_stay", state, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
